// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the divider and its parent.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             exception;
    logic             ready;
    logic             busy;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, exception, ready, busy
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, exception, ready, busy
    );
endinterface

// File: rtl/div_seq_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] diff;
    logic           neg;

    // A < M before the shift, so the shifted A is below 2M and the (WIDTH+1)-bit
    // difference lies in [-M, M-1]; its top bit is therefore a true sign.
    assign a_sh  = {a_i, q_i[WIDTH-1]};
    assign m_ext = {1'b0, m_i};
    assign diff  = a_sh - m_ext;
    assign neg   = diff[WIDTH];

    assign a_o = neg ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_seq.sv
// Iterative signed divider: one restoring step per cycle, truncating quotient.
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   LOAD  | take magnitudes/signs of latched operands, screen exceptions
//   RUN   | WIDTH shift-subtract steps
//   FIX   | apply signs, write quotient/remainder
//   DONE  | ready pulse; start here chains the next division
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // The remainder magnitude never reaches 2^WIDTH, so A is kept WIDTH wide;
    // the extra bit only exists inside the step's subtraction.
    div_step #(.WIDTH(WIDTH)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    // |MIN| wraps to MIN, which is the correct value read as unsigned.
    assign dvd_mag = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
    assign dvs_mag = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        exc_d    = exc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d      = '0;
                q_d      = dvd_mag;
                m_d      = dvs_mag;
                sign_q_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                sign_r_d = dvd_q[WIDTH-1];
                cnt_d    = '0;
                if (dvs_q == '0) begin
                    exc_d   = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                    state_d = DONE;
                end else if (dvd_q == MIN_VAL && dvs_q == '1) begin
                    exc_d   = 1'b1;
                    quo_d   = MIN_VAL;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = sign_q_q ? -q_q : q_q;
                rem_d   = sign_r_q ? -a_q : a_q;
                exc_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.exception = exc_q;
    assign bus.ready     = (state_q == DONE);
    assign bus.busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded random/directed bench for div_seq against a plain-arithmetic model.
module tb_div_seq;
    import div_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t mon_x;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_200_000;
        $display("FAIL watchdog: sim time exceeded at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int base);
        exp_t   x;
        longint sa;
        longint sb_v;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        x.a  = a;
        x.b  = b;
        if (b == 32'd0) begin
            x.q = 32'd0; x.r = 32'd0; x.e = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            x.q = INT_MIN; x.r = 32'd0; x.e = 1'b1;
        end else begin
            x.q = 32'(sa / sb_v); x.r = 32'(sa % sb_v); x.e = 1'b0;
        end
        x.due = base + (x.e ? 2 : DIV_WIDTH + 3);
        return x;
    endfunction

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 want no pulse (cycle %0d)", cyc);
            end else begin
                longint la, lb, lq, lr, ar, ab;
                mon_x = sb.pop_front();
                chk("quotient", bus.quotient, mon_x.q);
                chk("remainder", bus.remainder, mon_x.r);
                chk("exception", 32'(bus.exception), 32'(mon_x.e));
                chk("latency", 32'(cyc), 32'(mon_x.due));
                if (!mon_x.e) begin
                    la = longint'($signed(mon_x.a));
                    lb = longint'($signed(mon_x.b));
                    lq = longint'($signed(bus.quotient));
                    lr = longint'($signed(bus.remainder));
                    ar = (lr < 0) ? -lr : lr;
                    ab = (lb < 0) ? -lb : lb;
                    total++;
                    if (lq * lb + lr != la || ar >= ab) begin
                        bad++;
                        $display("FAIL invariant: got q=%0d r=%0d want %0d = q*%0d + r, |r|<|d|",
                                 lq, lr, la, lb);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b, cyc));
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus.ready !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        if (bus.ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready want ready within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    // Issue one op and leave the bench positioned in its DONE cycle.
    task automatic op(input logic [31:0] a, input logic [31:0] b);
        drive(a, b);
        step();
        bus.start = 1'b0;
        wait_ready();
    endtask

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) step();
        chk("reset_quotient", bus.quotient, 32'd0);
        chk("reset_remainder", bus.remainder, 32'd0);
        chk("reset_exception", 32'(bus.exception), 32'd0);
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        step();

        op(32'd100, 32'd7);                 step();
        op(-32'sd100, 32'd7);               step();
        op(32'd100, -32'sd7);               step();
        op(-32'sd100, -32'sd7);             step();
        op(32'h8000_0000, 32'hFFFF_FFFF);   step();
        op(32'd123, 32'd0);                 step();
        op(32'h8000_0000, 32'd1);           step();
        op(32'd0, 32'd5);                   step();

        // Start held through the tail of RUN/FIX; only the DONE-cycle start counts.
        n = cyc;
        drive(32'd100, 32'd7);
        step();
        bus.start = 1'b0;
        while (cyc < n + 30) step();
        bus.start    = 1'b1;
        bus.dividend = 32'h8000_0000;
        bus.divisor  = 32'd2;
        sb.push_back(model(32'h8000_0000, 32'd2, n + 35));
        while (cyc < n + 36) step();
        bus.start = 1'b0;
        wait_ready();
        step();

        // Abort in the middle of RUN.
        drive(32'd100, 32'd7);
        step();
        bus.start = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        sb.delete();
        step();
        chk("abort_quotient", bus.quotient, 32'd0);
        chk("abort_remainder", bus.remainder, 32'd0);
        chk("abort_exception", 32'(bus.exception), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        repeat (40) step();
        op(32'd7, 32'd3);                   step();

        // Start and operands wiggle while busy; result must follow the first pair.
        drive(32'd1000, -32'sd33);
        step();
        for (int i = 0; i < 20; i++) begin
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            chk("busy_in_flight", 32'(bus.busy), 32'd1);
            step();
        end
        bus.start = 1'b0;
        wait_ready();
        step();

        // Random back-to-back chain.
        for (int i = 0; i < 1400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
                3: a = INT_MIN;
                4: b = INT_MIN;
                default: ;
            endcase
            op(a, b);
        end
        step();
        repeat (5) step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending results want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
